// File: rtl/a23_gc_loader.sv
// Host-side sequencer for a23_gc_main: loads p/g/e init vectors from a word stream, runs the
// core for a programmed number of cycles, snapshots its output vector and streams it back.
module a23_gc_loader #(
  parameter int unsigned CODE_MEM_SIZE = 64,
  parameter int unsigned G_MEM_SIZE    = 64,
  parameter int unsigned E_MEM_SIZE    = 64,
  parameter int unsigned OUT_MEM_SIZE  = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [31:0]                  run_cycles,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_data,
  output logic [CODE_MEM_SIZE*32-1:0]  p_init,
  output logic [G_MEM_SIZE*32-1:0]     g_init,
  output logic [E_MEM_SIZE*32-1:0]     e_init,
  output logic                         core_rst,
  input  logic [OUT_MEM_SIZE*32-1:0]   o,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [2:0] {
    StIdle, StLoadP, StLoadG, StLoadE, StRun, StDrain, StDone
  } state_e;

  state_e                      state_q;
  logic [31:0]                 word_cnt_q;
  logic [31:0]                 run_cnt_q;
  logic [31:0]                 run_cycles_q;
  logic [OUT_MEM_SIZE*32-1:0]  snap_q;
  logic                        core_rst_q;
  logic                        xfer;

  always_comb begin
    in_ready  = (state_q == StLoadP) || (state_q == StLoadG) || (state_q == StLoadE);
    xfer      = in_valid & in_ready;
    out_valid = (state_q == StDrain);
    out_last  = out_valid && (word_cnt_q == 32'(OUT_MEM_SIZE - 1));
    busy      = (state_q != StIdle) && (state_q != StDone);
    done      = (state_q == StDone);
    core_rst  = core_rst_q;
    out_data  = '0;
    for (int unsigned k = 0; k < OUT_MEM_SIZE; k++) begin
      if (out_valid && word_cnt_q == 32'(k)) out_data = snap_q[k*32 +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      word_cnt_q   <= '0;
      run_cnt_q    <= '0;
      run_cycles_q <= '0;
      snap_q       <= '0;
      core_rst_q   <= 1'b1;
      p_init       <= '0;
      g_init       <= '0;
      e_init       <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q      <= StLoadP;
            run_cycles_q <= run_cycles;
            word_cnt_q   <= '0;
          end
        end
        StLoadP: begin
          if (xfer) begin
            for (int unsigned k = 0; k < CODE_MEM_SIZE; k++) begin
              if (word_cnt_q == 32'(k)) p_init[k*32 +: 32] <= in_data;
            end
            if (word_cnt_q == 32'(CODE_MEM_SIZE - 1)) begin
              word_cnt_q <= '0;
              state_q    <= StLoadG;
            end else begin
              word_cnt_q <= word_cnt_q + 32'd1;
            end
          end
        end
        StLoadG: begin
          if (xfer) begin
            for (int unsigned k = 0; k < G_MEM_SIZE; k++) begin
              if (word_cnt_q == 32'(k)) g_init[k*32 +: 32] <= in_data;
            end
            if (word_cnt_q == 32'(G_MEM_SIZE - 1)) begin
              word_cnt_q <= '0;
              state_q    <= StLoadE;
            end else begin
              word_cnt_q <= word_cnt_q + 32'd1;
            end
          end
        end
        StLoadE: begin
          if (xfer) begin
            for (int unsigned k = 0; k < E_MEM_SIZE; k++) begin
              if (word_cnt_q == 32'(k)) e_init[k*32 +: 32] <= in_data;
            end
            if (word_cnt_q == 32'(E_MEM_SIZE - 1)) begin
              word_cnt_q <= '0;
              run_cnt_q  <= '0;
              // A zero-length run never releases the core, so it drains its reset-state outputs.
              if (run_cycles_q == 32'd0) begin
                snap_q  <= o;
                state_q <= StDrain;
              end else begin
                core_rst_q <= 1'b0;
                state_q    <= StRun;
              end
            end else begin
              word_cnt_q <= word_cnt_q + 32'd1;
            end
          end
        end
        StRun: begin
          if (run_cnt_q == run_cycles_q - 32'd1) begin
            snap_q     <= o;
            core_rst_q <= 1'b1;
            word_cnt_q <= '0;
            state_q    <= StDrain;
          end else begin
            run_cnt_q <= run_cnt_q + 32'd1;
          end
        end
        StDrain: begin
          if (out_ready) begin
            if (word_cnt_q == 32'(OUT_MEM_SIZE - 1)) begin
              word_cnt_q <= '0;
              state_q    <= StDone;
            end else begin
              word_cnt_q <= word_cnt_q + 32'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
